// File: rtl/issue_queue_param.sv
// issue_queue_param
//   Collapsing issue queue between rename and EXE. Entries stay packed in
//   indices 0..count-1 with index 0 the oldest. Source tags are woken by CDB
//   broadcasts. Each cycle the oldest fully ready entry moves into a
//   registered issue stage guarded by a valid/ready handshake.
//
// Ports
//   CLK, RESET            clock, asynchronous active-low reset
//   enq_*                 rename-side enqueue (valid/ready, tags, ready bits, payload)
//   cdb_valid, cdb_tag    CDB_N wakeup broadcasts, port k at [k*PREG_W +: PREG_W]
//   flush                 synchronous squash of queue and issue register
//   iss_*                 registered issue stage (valid/ready, tags, payload)
//   count                 valid queue entries, issue register not included
module issue_queue_param #(
    parameter int DEPTH     = 16,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 82,
    parameter int CDB_N     = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [PREG_W-1:0]       enq_srcA,
    input  logic [PREG_W-1:0]       enq_srcB,
    input  logic                    enq_srcA_rdy,
    input  logic                    enq_srcB_rdy,
    input  logic [PREG_W-1:0]       enq_dst,
    input  logic [PAYLOAD_W-1:0]    enq_payload,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*PREG_W-1:0] cdb_tag,
    input  logic                    flush,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [PREG_W-1:0]       iss_srcA,
    output logic [PREG_W-1:0]       iss_srcB,
    output logic [PREG_W-1:0]       iss_dst,
    output logic [PAYLOAD_W-1:0]    iss_payload,
    output logic [CNT_W-1:0]        count
);

    logic [PREG_W-1:0]    r_srcA    [DEPTH];
    logic [PREG_W-1:0]    r_srcB    [DEPTH];
    logic [PREG_W-1:0]    r_dst     [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [DEPTH-1:0]     r_rdyA;
    logic [DEPTH-1:0]     r_rdyB;
    logic [CNT_W-1:0]     r_count;

    logic                 r_iss_valid;
    logic [PREG_W-1:0]    r_iss_srcA;
    logic [PREG_W-1:0]    r_iss_srcB;
    logic [PREG_W-1:0]    r_iss_dst;
    logic [PAYLOAD_W-1:0] r_iss_payload;

    logic [PREG_W-1:0]    w_nxt_srcA    [DEPTH];
    logic [PREG_W-1:0]    w_nxt_srcB    [DEPTH];
    logic [PREG_W-1:0]    w_nxt_dst     [DEPTH];
    logic [PAYLOAD_W-1:0] w_nxt_payload [DEPTH];
    logic [DEPTH-1:0]     w_nxt_rdyA;
    logic [DEPTH-1:0]     w_nxt_rdyB;

    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_wakeA;
    logic [DEPTH-1:0]     w_wakeB;
    logic                 w_sel_found;
    logic [CNT_W-1:0]     w_sel_idx;
    logic [PREG_W-1:0]    w_sel_srcA;
    logic [PREG_W-1:0]    w_sel_srcB;
    logic [PREG_W-1:0]    w_sel_dst;
    logic [PAYLOAD_W-1:0] w_sel_payload;
    logic                 w_load;
    logic                 w_remove;
    logic                 w_enq;
    logic [CNT_W-1:0]     w_enq_idx;

    function automatic logic f_cdb_hit(input logic [PREG_W-1:0]       tag,
                                       input logic [CDB_N-1:0]        vld,
                                       input logic [CDB_N*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_N; k++) begin
            if (vld[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign enq_ready = (r_count < CNT_W'(DEPTH));
    assign w_load    = !r_iss_valid || iss_ready;
    assign w_remove  = w_load && w_sel_found;
    assign w_enq     = enq_valid && enq_ready;
    assign w_enq_idx = r_count - CNT_W'(w_remove);

    // Select reads only registered ready bits; scanning from the top lets
    // the lowest qualifying index win.
    always_comb begin
        w_valid       = '0;
        w_sel_found   = 1'b0;
        w_sel_idx     = '0;
        w_sel_srcA    = '0;
        w_sel_srcB    = '0;
        w_sel_dst     = '0;
        w_sel_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = (CNT_W'(i) < r_count);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_valid[i] && r_rdyA[i] && r_rdyB[i]) begin
                w_sel_found   = 1'b1;
                w_sel_idx     = CNT_W'(i);
                w_sel_srcA    = r_srcA[i];
                w_sel_srcB    = r_srcB[i];
                w_sel_dst     = r_dst[i];
                w_sel_payload = r_payload[i];
            end
        end
    end

    // Next entry image: wakeup in place, collapse above the removed slot,
    // then write the new entry (with CDB snoop) at the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wakeA[i]       = r_rdyA[i] | f_cdb_hit(r_srcA[i], cdb_valid, cdb_tag);
            w_wakeB[i]       = r_rdyB[i] | f_cdb_hit(r_srcB[i], cdb_valid, cdb_tag);
            w_nxt_srcA[i]    = r_srcA[i];
            w_nxt_srcB[i]    = r_srcB[i];
            w_nxt_dst[i]     = r_dst[i];
            w_nxt_payload[i] = r_payload[i];
            w_nxt_rdyA[i]    = w_wakeA[i];
            w_nxt_rdyB[i]    = w_wakeB[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_remove && (CNT_W'(i) >= w_sel_idx)) begin
                w_nxt_srcA[i]    = r_srcA[i+1];
                w_nxt_srcB[i]    = r_srcB[i+1];
                w_nxt_dst[i]     = r_dst[i+1];
                w_nxt_payload[i] = r_payload[i+1];
                w_nxt_rdyA[i]    = w_wakeA[i+1];
                w_nxt_rdyB[i]    = w_wakeB[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_enq && (CNT_W'(i) == w_enq_idx)) begin
                w_nxt_srcA[i]    = enq_srcA;
                w_nxt_srcB[i]    = enq_srcB;
                w_nxt_dst[i]     = enq_dst;
                w_nxt_payload[i] = enq_payload;
                w_nxt_rdyA[i]    = enq_srcA_rdy | f_cdb_hit(enq_srcA, cdb_valid, cdb_tag);
                w_nxt_rdyB[i]    = enq_srcB_rdy | f_cdb_hit(enq_srcB, cdb_valid, cdb_tag);
            end
        end
    end

    // Entry contents past count are don't-care, so flush only clears count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_srcA[i]    <= '0;
                r_srcB[i]    <= '0;
                r_dst[i]     <= '0;
                r_payload[i] <= '0;
            end
            r_rdyA  <= '0;
            r_rdyB  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_srcA[i]    <= w_nxt_srcA[i];
                r_srcB[i]    <= w_nxt_srcB[i];
                r_dst[i]     <= w_nxt_dst[i];
                r_payload[i] <= w_nxt_payload[i];
            end
            r_rdyA <= w_nxt_rdyA;
            r_rdyB <= w_nxt_rdyB;
            if (flush) r_count <= '0;
            else       r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_remove);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_iss_valid   <= 1'b0;
            r_iss_srcA    <= '0;
            r_iss_srcB    <= '0;
            r_iss_dst     <= '0;
            r_iss_payload <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_load) begin
            r_iss_valid <= w_sel_found;
            if (w_sel_found) begin
                r_iss_srcA    <= w_sel_srcA;
                r_iss_srcB    <= w_sel_srcB;
                r_iss_dst     <= w_sel_dst;
                r_iss_payload <= w_sel_payload;
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_srcA    = r_iss_srcA;
    assign iss_srcB    = r_iss_srcB;
    assign iss_dst     = r_iss_dst;
    assign iss_payload = r_iss_payload;
    assign count       = r_count;

endmodule
